pe_request_latch: RTL and testbench

//  Upstream stage of the 8-bit priority encoder. Captures rising edges on raw request lines into
//  a pending register and drives the masked pending vector into the encoder's I input.

---
 rtl/pe_request_latch.sv | 121 ++++++++++++
 tb/tb_pe_request_latch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pe_request_latch.sv
// Request capture stage ahead of an 8-bit priority encoder.
// Each lane synchronises its raw request, turns rising edges into pending bits,
// and reports re-requests on already-pending lines as drops. The top exposes
// the masked pending vector to the encoder, turns the encoder's answer into a
// valid/ready grant, and keeps a saturating count of dropped requests.

module pe_request_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic clr,
  output logic pend,
  output logic drop
);
  logic req_s, req_q, rise;

  assign rise = req_s & ~req_q;
  // A rise that lands on an already-pending bit that is not being cleared is lost.
  assign drop = rise & pend & ~clr;

  // Two-stage request sample plus the pending bit; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_s <= 1'b0;
      req_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_s <= req;
      req_q <= req_s;
      pend  <= rise | (pend & ~clr);
    end
  end
endmodule

module pe_request_latch #(
  parameter int N    = 8,
  parameter int IDXW = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  output logic [N-1:0]    pend_o,
  input  logic [IDXW-1:0] enc_idx,
  input  logic            enc_none,
  output logic            grant_valid,
  input  logic            grant_ready,
  output logic [IDXW-1:0] grant_idx,
  output logic [CNTW-1:0] drop_cnt
);
  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state;
  logic [N-1:0]    pending;
  logic [N-1:0]    clr;
  logic [N-1:0]    drops;
  logic            accept;
  logic [CNTW:0]   ndrop;
  logic [CNTW:0]   sum;
  logic [CNTW-1:0] cnt_nxt;

  assign accept = (state == OFFER) && grant_ready;
  // Masked lines keep their pending state; they are only hidden from the encoder.
  assign pend_o = pending & mask;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign clr[i] = accept && (grant_idx == IDXW'(i));
    pe_request_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req[i]),
      .clr  (clr[i]),
      .pend (pending[i]),
      .drop (drops[i])
    );
  end

  // Add every lane that dropped this cycle and clamp at all-ones.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < N; i++) ndrop = ndrop + (CNTW+1)'(drops[i]);
    sum     = {1'b0, drop_cnt} + ndrop;
    cnt_nxt = sum[CNTW] ? {CNTW{1'b1}} : sum[CNTW-1:0];
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= '0;
    else        drop_cnt <= cnt_nxt;
  end

  // Grant FSM: latch the encoder result once, hold it until accepted, then idle one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!enc_none) begin
            grant_idx   <= enc_idx;
            grant_valid <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          if (grant_ready) begin
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pe_request_latch.sv
// Bench for pe_request_latch with a behavioural highest-index-wins encoder
// closing the loop from pend_o back to enc_idx/enc_none.

module tb_pe_request_latch;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, mask, pend_o;
  logic [2:0] enc_idx, grant_idx;
  logic       enc_none, grant_valid, grant_ready;
  logic [7:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pe_request_latch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask       (mask),
    .pend_o     (pend_o),
    .enc_idx    (enc_idx),
    .enc_none   (enc_none),
    .grant_valid(grant_valid),
    .grant_ready(grant_ready),
    .grant_idx  (grant_idx),
    .drop_cnt   (drop_cnt)
  );

  // Encoder model: highest set bit wins.
  always_comb begin
    enc_none = (pend_o == 8'h00);
    enc_idx  = 3'd0;
    for (int i = 0; i < 8; i++) if (pend_o[i]) enc_idx = 3'(i);
  end

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       rdy;
    logic       gv;
    logic [2:0] gi;
    logic [7:0] pend;
    logic [7:0] drop;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, settle just after it.
  task automatic cyc(input logic r, input logic [7:0] rq, input logic [7:0] mk, input logic rd);
    rst_n = r; req = rq; mask = mk; grant_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [7:0] rq, input logic [7:0] mk, input logic rd,
                     input logic gv, input logic [2:0] gi, input logic [7:0] pd);
    vt.push_back('{r, rq, mk, rd, gv, gi, pd, 8'h00});
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; mask = 8'hFF; grant_ready = 1'b0;

    // Reset with all requests held, then drain in priority order.
    add(0, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);
    add(0, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);
    add(0, 8'hFF, 8'hFF, 0, 0, 0, 8'h00);
    add(1, 8'hFF, 8'hFF, 1, 0, 0, 8'h00);
    add(1, 8'hFF, 8'hFF, 1, 0, 0, 8'hFF);
    add(1, 8'hFF, 8'hFF, 1, 1, 7, 8'hFF);
    add(1, 8'hFF, 8'hFF, 1, 0, 7, 8'h7F);
    add(1, 8'hFF, 8'hFF, 1, 1, 6, 8'h7F);
    add(1, 8'hFF, 8'hFF, 1, 0, 6, 8'h3F);
    add(1, 8'hFF, 8'hFF, 1, 1, 5, 8'h3F);
    add(1, 8'hFF, 8'hFF, 1, 0, 5, 8'h1F);
    add(1, 8'hFF, 8'hFF, 1, 1, 4, 8'h1F);
    add(1, 8'hFF, 8'hFF, 1, 0, 4, 8'h0F);
    add(1, 8'hFF, 8'hFF, 1, 1, 3, 8'h0F);
    add(1, 8'hFF, 8'hFF, 1, 0, 3, 8'h07);
    add(1, 8'hFF, 8'hFF, 1, 1, 2, 8'h07);
    add(1, 8'hFF, 8'hFF, 1, 0, 2, 8'h03);
    add(1, 8'hFF, 8'hFF, 1, 1, 1, 8'h03);
    add(1, 8'hFF, 8'hFF, 1, 0, 1, 8'h01);
    add(1, 8'hFF, 8'hFF, 1, 1, 0, 8'h01);
    add(1, 8'hFF, 8'hFF, 1, 0, 0, 8'h00);
    add(1, 8'h00, 8'hFF, 1, 0, 0, 8'h00);
    add(1, 8'h00, 8'hFF, 1, 0, 0, 8'h00);
    // Single one-cycle pulse on line 5.
    add(1, 8'h20, 8'hFF, 1, 0, 0, 8'h00);
    add(1, 8'h00, 8'hFF, 1, 0, 0, 8'h20);
    add(1, 8'h00, 8'hFF, 1, 1, 5, 8'h20);
    add(1, 8'h00, 8'hFF, 1, 0, 5, 8'h00);
    add(1, 8'h00, 8'hFF, 1, 0, 5, 8'h00);
    // Masked line 6 stays hidden until the mask opens.
    add(1, 8'h40, 8'h0F, 1, 0, 5, 8'h00);
    add(1, 8'h00, 8'h0F, 1, 0, 5, 8'h00);
    add(1, 8'h00, 8'h0F, 1, 0, 5, 8'h00);
    add(1, 8'h00, 8'h0F, 1, 0, 5, 8'h00);
    add(1, 8'h00, 8'hFF, 1, 1, 6, 8'h40);
    add(1, 8'h00, 8'hFF, 1, 0, 6, 8'h00);

    #2;
    foreach (vt[k]) begin
      cyc(vt[k].rst_n, vt[k].req, vt[k].mask, vt[k].rdy);
      chk($sformatf("v%0d grant_valid", k), grant_valid, vt[k].gv);
      chk($sformatf("v%0d grant_idx", k), grant_idx, vt[k].gi);
      chk($sformatf("v%0d pend_o", k), pend_o, vt[k].pend);
      chk($sformatf("v%0d drop_cnt", k), drop_cnt, vt[k].drop);
    end

    // Stall: offer on line 5 held for 10 cycles while line 7 arrives.
    cyc(1, 8'h24, 8'hFF, 0);
    cyc(1, 8'h00, 8'hFF, 0);
    chk("stall pend", pend_o, 8'h24);
    cyc(1, 8'h00, 8'hFF, 0);
    chk("stall first gv", grant_valid, 1'b1);
    chk("stall first gi", grant_idx, 3'd5);
    for (int i = 0; i < 10; i++) begin
      cyc(1, (i == 3) ? 8'h80 : 8'h00, 8'hFF, 0);
      chk($sformatf("stall%0d gv", i), grant_valid, 1'b1);
      chk($sformatf("stall%0d gi", i), grant_idx, 3'd5);
    end
    chk("stall pend after", pend_o, 8'hA4);
    chk("stall drop", drop_cnt, 8'd0);
    cyc(1, 8'h00, 8'hFF, 1);
    chk("rel acc5 gv", grant_valid, 1'b0);
    chk("rel acc5 pend", pend_o, 8'h84);
    cyc(1, 8'h00, 8'hFF, 1);
    chk("rel g7 gv", grant_valid, 1'b1);
    chk("rel g7 gi", grant_idx, 3'd7);
    cyc(1, 8'h00, 8'hFF, 1);
    chk("rel acc7 pend", pend_o, 8'h04);
    cyc(1, 8'h00, 8'hFF, 1);
    chk("rel g2 gv", grant_valid, 1'b1);
    chk("rel g2 gi", grant_idx, 3'd2);
    cyc(1, 8'h00, 8'hFF, 1);
    chk("rel acc2 pend", pend_o, 8'h00);
    chk("rel acc2 gv", grant_valid, 1'b0);

    // Collision: new edge on line 2 in the same cycle its grant is accepted.
    cyc(1, 8'h04, 8'hFF, 0);
    cyc(1, 8'h00, 8'hFF, 0);
    cyc(1, 8'h00, 8'hFF, 0);
    chk("col offer gi", grant_idx, 3'd2);
    cyc(1, 8'h04, 8'hFF, 0);
    cyc(1, 8'h00, 8'hFF, 1);
    chk("col pend kept", pend_o, 8'h04);
    chk("col gv", grant_valid, 1'b0);
    chk("col no drop", drop_cnt, 8'd0);
    cyc(1, 8'h00, 8'hFF, 0);
    chk("col regrant gv", grant_valid, 1'b1);
    chk("col regrant gi", grant_idx, 3'd2);

    // Re-pulse pending line 2 without accepting: counter must saturate.
    for (int i = 1; i <= 300; i++) begin
      cyc(1, 8'h04, 8'hFF, 0);
      cyc(1, 8'h00, 8'hFF, 0);
      if (i == 1)   chk("drop 1", drop_cnt, 8'd1);
      if (i == 100) chk("drop 100", drop_cnt, 8'd100);
      if (i == 255) chk("drop 255", drop_cnt, 8'd255);
    end
    chk("drop sat", drop_cnt, 8'd255);
    chk("drop gv held", grant_valid, 1'b1);

    // Reset in the middle of an offer.
    cyc(0, 8'h00, 8'hFF, 0);
    chk("rst offer gv", grant_valid, 1'b0);
    chk("rst offer pend", pend_o, 8'h00);
    chk("rst offer drop", drop_cnt, 8'd0);
    chk("rst offer gi", grant_idx, 3'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'h00, 8'hFF, 1);
      chk($sformatf("post rst%0d gv", i), grant_valid, 1'b0);
      chk($sformatf("post rst%0d pend", i), pend_o, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
